// File: rtl/noc_axi_wr_arbiter.sv
// Two-master to one-slave AXI4 write arbiter: round-robin grant held for AW, W burst and B.
// Latency: 1 cycle request-to-grant (registered); all channels then pass through combinationally.
// Backpressure: each phase holds indefinitely on slave/master READY low; the non-owner sees READY=0.
module noc_axi_wr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic                M0_AWVALID,
    output logic                M0_AWREADY,
    input  logic [ADDR_W-1:0]   M0_AWADDR,
    input  logic [LEN_W-1:0]    M0_AWLEN,
    input  logic [2:0]          M0_AWSIZE,
    input  logic [1:0]          M0_AWBURST,
    input  logic                M0_WVALID,
    input  logic                M0_WLAST,
    output logic                M0_WREADY,
    input  logic [DATA_W-1:0]   M0_WDATA,
    input  logic [DATA_W/8-1:0] M0_WSTRB,
    output logic                M0_BVALID,
    output logic [1:0]          M0_BRESP,
    input  logic                M0_BREADY,

    input  logic                M1_AWVALID,
    output logic                M1_AWREADY,
    input  logic [ADDR_W-1:0]   M1_AWADDR,
    input  logic [LEN_W-1:0]    M1_AWLEN,
    input  logic [2:0]          M1_AWSIZE,
    input  logic [1:0]          M1_AWBURST,
    input  logic                M1_WVALID,
    input  logic                M1_WLAST,
    output logic                M1_WREADY,
    input  logic [DATA_W-1:0]   M1_WDATA,
    input  logic [DATA_W/8-1:0] M1_WSTRB,
    output logic                M1_BVALID,
    output logic [1:0]          M1_BRESP,
    input  logic                M1_BREADY,

    output logic                S_AWVALID,
    input  logic                S_AWREADY,
    output logic [ADDR_W-1:0]   S_AWADDR,
    output logic [LEN_W-1:0]    S_AWLEN,
    output logic [2:0]          S_AWSIZE,
    output logic [1:0]          S_AWBURST,
    output logic                S_WVALID,
    input  logic                S_WREADY,
    output logic [DATA_W-1:0]   S_WDATA,
    output logic [DATA_W/8-1:0] S_WSTRB,
    output logic                S_WLAST,
    input  logic                S_BVALID,
    input  logic [1:0]          S_BRESP,
    output logic                S_BREADY,

    output logic [1:0]          GRANT,
    output logic                WLEN_ERR
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } aw_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             rr_last_q, rr_last_d;   // 1 = M1 was the last owner
    logic [LEN_W:0]   beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             wlen_err_q, wlen_err_d;

    aw_t  m0_aw, m1_aw, gnt_aw;
    w_t   m0_w, m1_w, gnt_w;
    logic gnt_awvalid, gnt_wvalid, gnt_bready;
    logic in_addr, in_data, in_resp;
    logic aw_hs, w_hs, b_hs;

    assign m0_aw = {M0_AWADDR, M0_AWLEN, M0_AWSIZE, M0_AWBURST};
    assign m1_aw = {M1_AWADDR, M1_AWLEN, M1_AWSIZE, M1_AWBURST};
    assign m0_w  = {M0_WDATA, M0_WSTRB, M0_WLAST};
    assign m1_w  = {M1_WDATA, M1_WSTRB, M1_WLAST};

    // Mux driven only by the registered grant, so slave-side signals stay stable under stall.
    always_comb begin
        gnt_aw      = '0;
        gnt_w       = '0;
        gnt_awvalid = 1'b0;
        gnt_wvalid  = 1'b0;
        gnt_bready  = 1'b0;
        if (grant_q[0]) begin
            gnt_aw      = m0_aw;
            gnt_w       = m0_w;
            gnt_awvalid = M0_AWVALID;
            gnt_wvalid  = M0_WVALID;
            gnt_bready  = M0_BREADY;
        end else if (grant_q[1]) begin
            gnt_aw      = m1_aw;
            gnt_w       = m1_w;
            gnt_awvalid = M1_AWVALID;
            gnt_wvalid  = M1_WVALID;
            gnt_bready  = M1_BREADY;
        end
    end

    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);
    assign in_resp = (state_q == RESP);

    assign S_AWVALID  = in_addr & gnt_awvalid;
    assign S_AWADDR   = gnt_aw.addr;
    assign S_AWLEN    = gnt_aw.len;
    assign S_AWSIZE   = gnt_aw.size;
    assign S_AWBURST  = gnt_aw.burst;
    assign M0_AWREADY = in_addr & grant_q[0] & S_AWREADY;
    assign M1_AWREADY = in_addr & grant_q[1] & S_AWREADY;

    assign S_WVALID  = in_data & gnt_wvalid;
    assign S_WDATA   = gnt_w.data;
    assign S_WSTRB   = gnt_w.strb;
    assign S_WLAST   = gnt_w.last;
    assign M0_WREADY = in_data & grant_q[0] & S_WREADY;
    assign M1_WREADY = in_data & grant_q[1] & S_WREADY;

    assign S_BREADY  = in_resp & gnt_bready;
    assign M0_BVALID = in_resp & grant_q[0] & S_BVALID;
    assign M1_BVALID = in_resp & grant_q[1] & S_BVALID;
    assign M0_BRESP  = (in_resp & grant_q[0]) ? S_BRESP : 2'b00;
    assign M1_BRESP  = (in_resp & grant_q[1]) ? S_BRESP : 2'b00;

    assign aw_hs = S_AWVALID & S_AWREADY;
    assign w_hs  = S_WVALID & S_WREADY;
    assign b_hs  = S_BVALID & S_BREADY;

    assign GRANT    = grant_q;
    assign WLEN_ERR = wlen_err_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_last_d  = rr_last_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        wlen_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (M0_AWVALID && M1_AWVALID) begin
                    grant_d = rr_last_q ? 2'b01 : 2'b10;
                    state_d = ADDR;
                end else if (M0_AWVALID) begin
                    grant_d = 2'b01;
                    state_d = ADDR;
                end else if (M1_AWVALID) begin
                    grant_d = 2'b10;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    len_d      = gnt_aw.len;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    // Early WLAST and missing WLAST on the final beat are both flagged.
                    if (gnt_w.last) begin
                        state_d    = RESP;
                        wlen_err_d = (beat_cnt_q != {1'b0, len_q});
                    end else begin
                        wlen_err_d = (beat_cnt_q == {1'b0, len_q});
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    rr_last_d = grant_q[1];
                    grant_d   = 2'b00;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            rr_last_q  <= 1'b1;
            beat_cnt_q <= '0;
            len_q      <= '0;
            wlen_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            wlen_err_q <= wlen_err_d;
        end
    end

endmodule

// File: doc/noc_axi_wr_arbiter.md
Name: noc_axi_wr_arbiter

Overview:
- Two-master to one-slave AXI4 write-path arbiter in the NOC master-side fabric.
- Arbitrates the M0/M1 write-address requests round-robin and locks the grant for the whole transaction (AW, W burst, B response).
- Steers the winner's AW/W signals to the slave port and routes BRESP back to that master.
- Counts W beats against AWLEN and flags burst-length mismatches.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, write data width; strobe width is DATA_W/8
- LEN_W, 4, AWLEN width (burst length = AWLEN+1, 1..16 beats)

Ports:
- ACLK  input  1  fabric clock
- ARESETn  input  1  asynchronous active-low reset
- Mx_AWVALID / Mx_AWREADY  in/out  1  per-master (x=0,1) address handshake
- Mx_AWADDR, Mx_AWLEN, Mx_AWSIZE, Mx_AWBURST  input  ADDR_W/LEN_W/3/2  per-master address attributes
- Mx_WVALID, Mx_WLAST / Mx_WREADY  in/out  1  per-master write data handshake
- Mx_WDATA, Mx_WSTRB  input  DATA_W, DATA_W/8  per-master write data and strobe
- Mx_BVALID, Mx_BRESP / Mx_BREADY  out/in  1, 2 / 1  per-master write response
- S_AWVALID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST / S_AWREADY  out/in  slave address channel
- S_WVALID, S_WDATA, S_WSTRB, S_WLAST / S_WREADY  out/in  slave write data channel
- S_BVALID, S_BRESP / S_BREADY  in/out  slave response channel
- GRANT  output  2  one-hot current owner (00 = none)
- WLEN_ERR  output  1  one-cycle pulse when WLAST does not fall on the AWLEN+1 beat

Behaviour:
- Interface: one clock, ACLK. Reset ARESETn is asynchronous and active-low.
- Reset state: state=IDLE, GRANT=00, rr_last=M1 (so M0 wins first), beat_cnt=0, WLEN_ERR=0.
- Reset outputs: all S_*VALID, Mx_*READY, Mx_BVALID and S_BREADY are 0; muxed data outputs are 0.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: if any Mx_AWVALID, register the winner into GRANT and move to ADDR next cycle. Arbitration latency is 1 cycle; there is no combinational path from AWVALID to the slave.
- Round-robin: if both request, grant the master that is not rr_last. If only one requests, it wins.
- ADDR:
  - S_AWVALID = granted Mx_AWVALID; S_AW* = granted attributes.
  - Granted Mx_AWREADY = S_AWREADY; the other master's AWREADY stays 0.
  - On S_AWVALID&&S_AWREADY: latch AWLEN into len_q, clear beat_cnt, go to DATA.
- DATA:
  - W signals are muxed from the granted master; the non-granted master's WREADY = 0.
  - Each W handshake increments beat_cnt (LEN_W+1 bits).
  - On a handshake with WLAST=1: go to RESP. If beat_cnt != len_q, pulse WLEN_ERR.
  - On a handshake at beat_cnt==len_q with WLAST=0: pulse WLEN_ERR and continue until WLAST.
  - W beats presented before the AW handshake are not accepted (WREADY=0 outside DATA).
- RESP:
  - Granted Mx_BVALID/Mx_BRESP = S_BVALID/S_BRESP; S_BREADY = granted Mx_BREADY.
  - On the B handshake: rr_last <= GRANT, GRANT <= 00, go to IDLE.
  - The next grant can be issued the cycle after IDLE is re-entered.
- A requester that drops AWVALID before its handshake violates AXI. No recovery is required; the arbiter stays in ADDR.
- A new request arriving during DATA or RESP waits. There is no preemption.
- Back-pressure: every stage holds indefinitely while the slave READY is 0. Values are held stable (combinational pass-through of the registered grant).
- Reset asserted mid-transaction: return immediately to the reset state; the in-flight burst is abandoned.

Test Plan:
- Single M0 write, AWLEN=3, S_AWREADY=1, S_WREADY=1 -> GRANT=01 one cycle after AWVALID; 4 W beats reach S_W*; BRESP=00 returned on M0_B*; GRANT=00 after B handshake; WLEN_ERR never asserted.
- M0 and M1 request AWVALID in the same cycle, both AWLEN=0, repeated 4 times -> grants alternate M0, M1, M0, M1; M1 AWREADY=0 while M0 is granted.
- M1 granted, S_WREADY toggling 0/1 every cycle, AWLEN=7 -> exactly 8 beats transferred; S_WDATA/S_WSTRB stable while S_WREADY=0.
- AWLEN=3 but WLAST on beat 2 -> WLEN_ERR pulses 1 cycle at that beat; FSM goes to RESP and completes normally.
- M1 AWVALID raised while the M0 transaction is in RESP with S_BVALID delayed 5 cycles -> M1 is not granted until after the M0 B handshake, then GRANT=10.
- ARESETn pulled low in DATA after 2 of 4 beats -> all VALID/READY outputs 0 and GRANT=00 asynchronously; after release, M0 is granted first.
